// File: rtl/serial_pattern_tx_if.sv
// Word-in / bit-out bus of the serial pattern transmitter.
// The master side supplies words; the slave side (the transmitter) drives the status and the serial line.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             x_out;
  logic             busy;
  logic             done;
  logic [7:0]       frame_cnt;

  modport master (
    output data_in, valid_in,
    input  ready_out, x_out, busy, done, frame_cnt
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, x_out, busy, done, frame_cnt
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial frame transmitter: MSB-first frame of WIDTH bits, then GAP idle-low cycles.
// Moore outputs only; every output is decoded from registered state.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_tx_if.slave  bus
);

  localparam int BIT_CW = $clog2(WIDTH);
  localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_shift;
  logic [BIT_CW-1:0] r_bit_cnt;
  logic [GAP_CW-1:0] r_gap_cnt;
  logic              r_done;
  logic [7:0]        r_frame_cnt;
  logic              w_accept;
  logic              w_frame_end;
  logic              w_bit_last;
  logic              w_gap_last;

  assign w_bit_last = (r_bit_cnt == BIT_LAST);
  assign w_gap_last = (r_gap_cnt == GAP_LAST);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_in) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_bit_last) begin
          if (GAP == 0) begin
            w_next      = S_IDLE;
            w_frame_end = 1'b1;
          end else begin
            w_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_next      = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      r_done  <= w_frame_end;
      if (w_frame_end)
        r_frame_cnt <= r_frame_cnt + 8'd1;
      // Counters return to zero on their last value so they never wrap past their range.
      if (w_accept) begin
        r_shift   <= bus.data_in;
        r_bit_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
        r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
      end
      if (r_state == S_GAP)
        r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + 1'b1;
      else
        r_gap_cnt <= '0;
    end
  end

  assign bus.ready_out = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.x_out     = (r_state == S_SHIFT) & r_shift[WIDTH-1];
  assign bus.done      = r_done;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: a GAP=2 instance and a GAP=0 instance on a shared clock and reset.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(8)) bus  ();
  serial_pattern_tx_if #(.WIDTH(8)) bus0 ();

  serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks cycles T1..T8 of a frame on the GAP=2 instance, leaving the bench in T9.
  task automatic expect_bits(input string tag, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("%s_x_b%0d", tag, i), bus.x_out, d[i]);
      check($sformatf("%s_busy_b%0d", tag, i), bus.busy, 1);
      tick();
    end
  endtask

  task automatic expect_gap(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_gap_x%0d", tag, i), bus.x_out, 0);
      check($sformatf("%s_gap_busy%0d", tag, i), bus.busy, 1);
      check($sformatf("%s_gap_rdy%0d", tag, i), bus.ready_out, 0);
      tick();
    end
  endtask

  initial begin
    int dones;
    int cyc;
    logic [7:0] c3;
    bus.data_in   = 8'h00;
    bus.valid_in  = 1'b0;
    bus0.data_in  = 8'h00;
    bus0.valid_in = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", bus.ready_out, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_x", bus.x_out, 0);
    check("rst_done", bus.done, 0);
    check("rst_fcnt", bus.frame_cnt, 0);

    // Single frame 0xA5
    bus.data_in  = 8'hA5;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("a5_ready_t1", bus.ready_out, 0);
    expect_bits("a5", 8'hA5);
    expect_gap("a5");
    check("a5_done", bus.done, 1);
    check("a5_ready_t11", bus.ready_out, 1);
    check("a5_busy_t11", bus.busy, 0);
    check("a5_fcnt", bus.frame_cnt, 1);
    tick();
    check("a5_done_pulse", bus.done, 0);
    check("a5_x_idle", bus.x_out, 0);

    // Back-to-back 0xFF then 0x01 with valid held high
    bus.data_in  = 8'hFF;
    bus.valid_in = 1'b1;
    tick();
    bus.data_in = 8'h01;
    expect_bits("ff", 8'hFF);
    expect_gap("ff");
    check("ff_done", bus.done, 1);
    check("ff_ready", bus.ready_out, 1);
    check("ff_fcnt", bus.frame_cnt, 2);
    tick();
    bus.valid_in = 1'b0;
    check("b2b_busy_t1", bus.busy, 1);
    expect_bits("01", 8'h01);
    expect_gap("01");
    check("01_done", bus.done, 1);
    check("01_fcnt", bus.frame_cnt, 3);
    tick();

    // Word offered while busy is dropped
    c3 = 8'hC3;
    bus.data_in  = 8'hC3;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        bus.data_in  = 8'h3C;
        bus.valid_in = 1'b1;
      end
      check($sformatf("c3_x_b%0d", i), bus.x_out, c3[i]);
      tick();
      bus.valid_in = 1'b0;
    end
    expect_gap("c3");
    check("c3_done", bus.done, 1);
    check("c3_fcnt", bus.frame_cnt, 4);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("c3_idle_busy%0d", i), bus.busy, 0);
      check($sformatf("c3_idle_x%0d", i), bus.x_out, 0);
    end
    check("c3_fcnt_after", bus.frame_cnt, 4);

    // Reset mid-frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.data_in  = 8'hAA;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      check($sformatf("aa_x_b%0d", i), bus.x_out, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_x", bus.x_out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.ready_out, 1);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_fcnt", bus.frame_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("mid_rst_nodone%0d", i), bus.done, 0);
    end
    check("mid_rst_fcnt_after", bus.frame_cnt, 0);

    // GAP=0 instance: 0x80, then 0xC0 accepted in the done cycle
    bus0.data_in  = 8'h80;
    bus0.valid_in = 1'b1;
    tick();
    bus0.valid_in = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("g0_x_b%0d", i), bus0.x_out, (i == 7) ? 1 : 0);
      check($sformatf("g0_busy_b%0d", i), bus0.busy, 1);
      tick();
    end
    check("g0_done_t9", bus0.done, 1);
    check("g0_ready_t9", bus0.ready_out, 1);
    check("g0_fcnt_t9", bus0.frame_cnt, 1);
    bus0.data_in  = 8'hC0;
    bus0.valid_in = 1'b1;
    tick();
    bus0.valid_in = 1'b0;
    check("g0_next_msb_t10", bus0.x_out, 1);
    check("g0_next_busy_t10", bus0.busy, 1);
    check("g0_done_t10", bus0.done, 0);
    for (int i = 0; i < 10; i++) tick();

    // Frame counter wrap on the GAP=2 instance
    dones = 0;
    cyc   = 0;
    bus.data_in  = 8'h5A;
    bus.valid_in = 1'b1;
    while (dones < 256 && cyc < 4000) begin
      tick();
      cyc++;
      if (bus.done) begin
        dones++;
        if (dones == 255) check("wrap_fcnt_255", bus.frame_cnt, 255);
        if (dones == 256) begin
          bus.valid_in = 1'b0;
          check("wrap_fcnt_0", bus.frame_cnt, 0);
        end
      end
    end
    bus.valid_in = 1'b0;
    check("wrap_period_cycles", cyc, 256 * 11);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("wrap_done_pulses", dones, 256);
    check("wrap_idle_busy", bus.busy, 0);
    check("wrap_fcnt_final", bus.frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per frame (legal range 2..32).
REQ-002 SHALL have parameter GAP, default 2, meaning idle-low cycles after each frame (legal range 0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port valid_in  input  1  data_in is valid.
REQ-007 SHALL have port ready_out  output  1  block accepts a word this cycle.
REQ-008 SHALL have port x_out  output  1  serial bitstream, MSB first.
REQ-009 SHALL have port busy  output  1  a frame or gap is in progress.
REQ-010 SHALL have port done  output  1  single-cycle frame-complete pulse.
REQ-011 SHALL have port frame_cnt  output  8  count of completed frames.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, SHIFT, GAP; every output SHALL be a function of registered state only, with no combinational input-to-output path.
REQ-013 SHALL drive ready_out=1 exactly when state is IDLE.
REQ-014 SHALL accept a word at the rising edge where valid_in=1 and ready_out=1; data_in SHALL be sampled only at that edge.
REQ-015 On acceptance, SHALL load the shift register and bit counter (0) and enter SHIFT.
REQ-016 In cycles T1..TWIDTH after acceptance (acceptance edge ends T0), SHALL drive x_out = data bit WIDTH-1, WIDTH-2, ..., 0 in order, one bit per cycle.
REQ-017 SHALL drive busy=1 in SHIFT and GAP, and busy=0 in IDLE.
REQ-018 After bit 0, SHALL enter GAP for exactly GAP cycles (TWIDTH+1..TWIDTH+GAP) with x_out=0; if GAP=0, SHALL go from SHIFT directly to IDLE.
REQ-019 On entering IDLE after a frame, SHALL assert done=1 for exactly that first IDLE cycle and increment frame_cnt at the same edge.
REQ-020 frame_cnt SHALL wrap modulo 256 (255 -> 0) without a flag.
REQ-021 SHALL drive x_out=0 in IDLE.
REQ-022 SHALL ignore valid_in while busy=1; there is no buffering, and the word SHALL NOT be captured later.
REQ-023 If valid_in=1 in the done cycle, SHALL accept that word (back-to-back); the minimum frame period is WIDTH+GAP+1 cycles.
REQ-024 Bit and gap counters SHALL be sized $clog2 of their range; counting SHALL never underflow or overflow for legal parameters.

Reset
REQ-025 When rst=1 at a rising edge, SHALL set state=IDLE, x_out=0, busy=0, done=0, ready_out=1 (from the next cycle), frame_cnt=0, and clear the shift register and counters.
REQ-026 rst SHALL take priority over acceptance and over any in-progress frame.
REQ-027 A frame interrupted by rst SHALL be abandoned, SHALL NOT produce done, and SHALL NOT increment frame_cnt.

Verification (WIDTH=8, GAP=2 unless stated)
REQ-028 Single frame: rst, then one-cycle valid_in with data_in=0xA5 -> x_out T1..T8 = 1,0,1,0,0,1,0,1; T9,T10 = 0,0 with busy=1; T11 done=1, ready_out=1, frame_cnt=1.
REQ-029 Back-to-back: valid_in held high with 0xFF then 0x01 -> second acceptance in the first done cycle; 11-cycle frame period; x_out = eight 1s, 0,0, then 0,0,0,0,0,0,0,1.
REQ-030 Busy ignore: valid_in pulse with 0x3C at T4 of a 0xC3 frame -> output is only 0xC3's bits; no second frame; frame_cnt increments by 1.
REQ-031 Reset mid-frame: rst at T5 of a 0xAA frame -> next cycle x_out=0, busy=0, ready_out=1, no done, frame_cnt unchanged at 0.
REQ-032 GAP=0 build: 0x80 -> x_out = 1 then seven 0s; done in T9; next word accepted in T9 -> its MSB appears in T10.
REQ-033 Counter wrap: 256 consecutive frames -> frame_cnt reads 255 after frame 255, then 0 after frame 256, and done pulses exactly 256 times.
